// File: rtl/dmi_boot_sequencer.sv
// dmi_boot_sequencer
//   Hardware DMI master that hands a hart off to its boot address without a
//   debugger: activate the DM, halt the selected hart, load DPC with
//   BOOT_ADDR through an abstract command, then resume the hart.
//   Exactly one DMI transaction is in flight at any time.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  pulse; accepted only while idle
//   busy_o                   sequence in progress (DMI mux grant)
//   done_o                   one-cycle pulse on success
//   error_o, err_code_o      sticky failure flag and cause (cleared on start)
//                              1 resp!=0, 2 halt timeout, 3 cmderr,
//                              4 abstract busy timeout, 5 resume timeout
//   dmi_req_*                request channel (op 1 = read, 2 = write)
//   dmi_resp_*               response channel (resp 0 = OK)
module dmi_boot_sequencer #(
    parameter logic [63:0] BOOT_ADDR  = 64'h0000_0000_8000_0080,
    parameter logic [9:0]  HARTSEL    = 10'd0,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [2:0]  err_code_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [6:0]  dmi_req_addr_o,
    output logic [1:0]  dmi_req_op_o,
    output logic [31:0] dmi_req_data_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [31:0] dmi_resp_data_i,
    input  logic [1:0]  dmi_resp_resp_i
);
    localparam int unsigned CW = $clog2(POLL_LIMIT + 1);
    // dmcontrol with dmactive set and hartsello selecting the target hart
    localparam logic [31:0] DC = 32'h1 | {6'd0, HARTSEL, 16'd0};

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_WAIT, ST_DONE, ST_ERROR
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          error_q, error_d;
    logic [2:0]    code_q, code_d;

    logic [CW-1:0] cnt_inc;
    logic          is_poll, poll_ok;
    logic [2:0]    poll_code;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            step_q  <= 4'd0;
            cnt_q   <= '0;
            error_q <= 1'b0;
            code_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
            code_q  <= code_d;
        end
    end

    // Request fields depend only on the step, so they stay stable while
    // the DM holds ready low.
    always_comb begin
        dmi_req_addr_o = 7'h00;
        dmi_req_op_o   = 2'd2;
        dmi_req_data_o = 32'h0;
        unique case (step_q)
            4'd0:  begin dmi_req_addr_o = 7'h10; dmi_req_data_o = 32'h1; end
            4'd1:  begin dmi_req_addr_o = 7'h10; dmi_req_data_o = DC | 32'h8000_0000; end
            4'd2:  begin dmi_req_addr_o = 7'h11; dmi_req_op_o = 2'd1; end
            4'd3:  begin dmi_req_addr_o = 7'h10; dmi_req_data_o = DC; end
            4'd4:  begin dmi_req_addr_o = 7'h04; dmi_req_data_o = BOOT_ADDR[31:0]; end
            4'd5:  begin dmi_req_addr_o = 7'h05; dmi_req_data_o = BOOT_ADDR[63:32]; end
            4'd6:  begin dmi_req_addr_o = 7'h17; dmi_req_data_o = 32'h0033_07B1; end
            4'd7:  begin dmi_req_addr_o = 7'h16; dmi_req_op_o = 2'd1; end
            4'd8:  begin dmi_req_addr_o = 7'h10; dmi_req_data_o = DC | 32'h4000_0000; end
            4'd9:  begin dmi_req_addr_o = 7'h11; dmi_req_op_o = 2'd1; end
            4'd10: begin dmi_req_addr_o = 7'h10; dmi_req_data_o = DC; end
            default: ;
        endcase
    end

    // Poll steps: exit condition and timeout code
    always_comb begin
        is_poll   = (step_q == 4'd2) || (step_q == 4'd7) || (step_q == 4'd9);
        poll_ok   = dmi_resp_data_i[17];
        poll_code = 3'd5;
        if (step_q == 4'd2) begin
            poll_ok   = dmi_resp_data_i[9];
            poll_code = 3'd2;
        end else if (step_q == 4'd7) begin
            poll_ok   = !dmi_resp_data_i[12];
            poll_code = 3'd4;
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    // Next state
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        code_d  = code_q;
        unique case (state_q)
            ST_IDLE: if (start_i) begin
                state_d = ST_REQ;
                step_d  = 4'd0;
                cnt_d   = '0;
                error_d = 1'b0;
                code_d  = 3'd0;
            end
            ST_REQ: if (dmi_req_ready_i) state_d = ST_WAIT;
            ST_WAIT: if (dmi_resp_valid_i) begin
                if (dmi_resp_resp_i != 2'd0) begin
                    state_d = ST_ERROR; error_d = 1'b1; code_d = 3'd1;
                end else if (step_q == 4'd7 && dmi_resp_data_i[10:8] != 3'd0) begin
                    state_d = ST_ERROR; error_d = 1'b1; code_d = 3'd3;
                end else if (is_poll && !poll_ok) begin
                    // A met condition on the last allowed read still advances
                    if (cnt_inc == CW'(POLL_LIMIT)) begin
                        state_d = ST_ERROR; error_d = 1'b1; code_d = poll_code;
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = ST_REQ;
                    end
                end else if (step_q == 4'd10) begin
                    state_d = ST_DONE;
                end else begin
                    step_d  = step_q + 4'd1;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy_o           = (state_q == ST_REQ) || (state_q == ST_WAIT);
        done_o           = (state_q == ST_DONE);
        dmi_req_valid_o  = (state_q == ST_REQ);
        dmi_resp_ready_o = (state_q == ST_WAIT);
        error_o          = error_q;
        err_code_o       = code_q;
    end
endmodule
